// File: rtl/sent_pkg.sv
// rtl/sent_pkg.sv - shared encodings and constants for the SENT CRC engine
package sent_pkg;

    localparam logic MODE_LEGACY      = 1'b0;
    localparam logic MODE_RECOMMENDED = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        AUGMENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] CRC4_POLY = 4'hD;
    localparam logic [3:0] CRC4_SEED = 4'h5;
    localparam logic [5:0] CRC6_POLY = 6'h19;
    localparam logic [5:0] CRC6_SEED = 6'h15;

endpackage

// File: rtl/sent_crc_step.sv
// rtl/sent_crc_step.sv - combinational CRC update of one DIN_W beat, MSB first
module sent_crc_step #(
    parameter int CRC_W = 4,
    parameter int DIN_W = 4,
    parameter logic [CRC_W-1:0] POLY = 4'hD
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [DIN_W-1:0] din,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] c;
    logic             fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = DIN_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ din[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/sent_crc_engine.sv
// rtl/sent_crc_engine.sv - parametrised nibble-serial CRC engine with optional zero-beat augmentation
module sent_crc_engine
    import sent_pkg::*;
#(
    parameter int CRC_W = 4,
    parameter int DIN_W = 4,
    parameter logic [CRC_W-1:0] POLY = CRC4_POLY,
    parameter logic [CRC_W-1:0] SEED = CRC4_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [DIN_W-1:0] din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    input  logic [CRC_W-1:0] crc_rx,
    output logic [CRC_W-1:0] crc_out,
    output logic             crc_valid,
    output logic             crc_ok,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic             mode_q;
    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_rx_q;
    logic [CRC_W-1:0] step_out;
    logic [DIN_W-1:0] step_din;
    logic [CRC_W-1:0] cmp_rx;
    logic             accept;

    assign din_ready = (state == ACCUM);
    assign busy      = (state == ACCUM) || (state == AUGMENT);
    assign crc_valid = (state == DONE);
    // start wins over a beat presented in the same cycle
    assign accept    = din_valid && din_ready && !start;
    assign step_din  = (state == AUGMENT) ? '0 : din;
    // legacy finishes in the same cycle crc_rx is presented, so compare it directly
    assign cmp_rx    = (state == AUGMENT) ? crc_rx_q : crc_rx;

    sent_crc_step #(
        .CRC_W (CRC_W),
        .DIN_W (DIN_W),
        .POLY  (POLY)
    ) u_step (
        .crc_in  (crc_q),
        .din     (step_din),
        .crc_out (step_out)
    );

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ACCUM;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                ACCUM:   if (accept && din_last)
                             state_next = (mode_q == MODE_RECOMMENDED) ? AUGMENT : DONE;
                AUGMENT: state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            crc_q    <= SEED;
            crc_out  <= SEED;
            crc_ok   <= 1'b0;
            mode_q   <= MODE_LEGACY;
            crc_rx_q <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                crc_q  <= SEED;
                mode_q <= mode;
            end else if (accept || state == AUGMENT) begin
                crc_q <= step_out;
            end
            if (accept && din_last) begin
                crc_rx_q <= crc_rx;
            end
            // results are published on entry to DONE so they line up with crc_valid
            if (state_next == DONE && state != DONE) begin
                crc_out <= step_out;
                crc_ok  <= (step_out == cmp_rx);
            end
        end
    end

endmodule

// File: tb/tb_sent_crc_engine.sv
// tb/tb_sent_crc_engine.sv - randomized self-checking bench for sent_crc_engine
module tb_sent_crc_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, mode = 1'b0;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0, din_last = 1'b0;
    logic       din_ready;
    logic [3:0] crc_rx = '0;
    logic [3:0] crc_out;
    logic       crc_valid, crc_ok, busy;

    logic       start6 = 1'b0, mode6 = 1'b0;
    logic [3:0] din6 = '0;
    logic       din_valid6 = 1'b0, din_last6 = 1'b0;
    logic       din_ready6;
    logic [5:0] crc_rx6 = '0;
    logic [5:0] crc_out6;
    logic       crc_valid6, crc_ok6, busy6;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit check_en = 1'b0;

    typedef struct {
        int       due;
        logic [3:0] crc;
        logic     ok;
    } exp_t;
    exp_t expq[$];
    logic [3:0] hold_crc = 4'h5;
    logic       hold_ok = 1'b0;
    logic [3:0] mb[$];
    int         mg[$];

    sent_crc_engine dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .din(din),
        .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
        .crc_rx(crc_rx), .crc_out(crc_out), .crc_valid(crc_valid),
        .crc_ok(crc_ok), .busy(busy)
    );

    sent_crc_engine #(.CRC_W(6), .DIN_W(4), .POLY(6'h19), .SEED(6'h15)) dut6 (
        .clk(clk), .reset(reset), .start(start6), .mode(mode6), .din(din6),
        .din_valid(din_valid6), .din_last(din_last6), .din_ready(din_ready6),
        .crc_rx(crc_rx6), .crc_out(crc_out6), .crc_valid(crc_valid6),
        .crc_ok(crc_ok6), .busy(busy6)
    );

    always #5 clk = ~clk;

    // Reference: treat the message as a bit string (recommended mode appends
    // a zero nibble) and run the LFSR division bit by bit with integers.
    function automatic int model_crc(int w, int poly, int seed, int m, input logic [3:0] b[$]);
        int r, mask, bt, top, nb;
        logic [3:0] msg[$];
        msg = b;
        if (m != 0) msg.push_back(4'h0);
        mask = (1 << w) - 1;
        r = seed;
        nb = msg.size();
        for (int k = 0; k < nb; k++) begin
            for (int j = 3; j >= 0; j--) begin
                bt  = (int'(msg[k]) >> j) & 1;
                top = (r >> (w - 1)) & 1;
                r   = ((r << 1) & mask) ^ (((top ^ bt) != 0) ? poly : 0);
            end
        end
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            hold_crc = 4'h5;
            hold_ok  = 1'b0;
            expq.delete();
        end
    end

    always @(negedge clk) begin
        if (!reset && check_en) begin
            logic exp_v;
            if (expq.size() > 0 && expq[0].due < cyc) begin
                chk("crc_valid_missed", 0, 1);
                void'(expq.pop_front());
            end
            exp_v = (expq.size() > 0) && (expq[0].due == cyc);
            chk("crc_valid", int'(crc_valid), int'(exp_v));
            if (exp_v) begin
                chk("crc_out", int'(crc_out), int'(expq[0].crc));
                chk("crc_ok", int'(crc_ok), int'(expq[0].ok));
                hold_crc = expq[0].crc;
                hold_ok  = expq[0].ok;
                void'(expq.pop_front());
            end else begin
                chk("crc_out_hold", int'(crc_out), int'(hold_crc));
                chk("crc_ok_hold", int'(crc_ok), int'(hold_ok));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(logic m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    task automatic gap(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("ready_in_gap", int'(din_ready), 1);
            chk("busy_in_gap", int'(busy), 1);
            tick();
        end
    endtask

    task automatic beat(logic [3:0] d, logic last, logic [3:0] rx);
        din       = d;
        din_valid = 1'b1;
        din_last  = last;
        crc_rx    = rx;
        @(negedge clk);
        chk("din_ready", int'(din_ready), 1);
        acc_cyc = cyc;
        tick();
        din_valid = 1'b0;
        din_last  = 1'b0;
        din       = $urandom_range(0, 15);
    endtask

    task automatic send_msg(logic m, logic [3:0] rx, logic [3:0] exp_crc);
        exp_t e;
        int n;
        n = mb.size();
        do_start(m);
        for (int i = 0; i < n; i++) begin
            gap(mg[i]);
            beat(mb[i], (i == n - 1), rx);
        end
        e.due = acc_cyc + 1 + int'(m);
        e.crc = exp_crc;
        e.ok  = (exp_crc == rx);
        expq.push_back(e);
        repeat (3) tick();
        @(negedge clk);
        chk("idle_ready", int'(din_ready), 0);
        chk("idle_busy", int'(busy), 0);
        tick();
    endtask

    initial begin
        logic [3:0] q0[$];
        logic [3:0] q00[$];
        logic [3:0] rx;
        logic [3:0] ec;
        logic       m;
        int         n;

        q0.push_back(4'h0);
        q00.push_back(4'h0);
        q00.push_back(4'h0);
        chk("model_crc4_legacy", model_crc(4, 13, 5, 0, q0), 4'h3);
        chk("model_crc4_recommended", model_crc(4, 13, 5, 1, q0), 4'hA);
        chk("model_crc4_two_zero", model_crc(4, 13, 5, 0, q00), 4'hA);
        chk("model_crc6_legacy", model_crc(6, 'h19, 'h15, 0, q0), 6'h34);

        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_crc_out", int'(crc_out), 4'h5);
        chk("rst_crc_valid", int'(crc_valid), 0);
        chk("rst_crc_ok", int'(crc_ok), 0);
        chk("rst_din_ready", int'(din_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst6_crc_out", int'(crc_out6), 6'h15);
        tick();
        check_en = 1'b1;

        // directed: legacy, compare ok then compare mismatch
        mb = {4'h0}; mg = {0};
        send_msg(1'b0, 4'h3, 4'h3);
        send_msg(1'b0, 4'h4, 4'h3);
        // recommended single zero nibble
        send_msg(1'b1, 4'hA, 4'hA);
        // two zero beats with 3-cycle gap
        mb = {4'h0, 4'h0}; mg = {0, 3};
        send_msg(1'b0, 4'h0, 4'hA);

        // CRC6 instance, legacy, one zero nibble
        start6 = 1'b1; mode6 = 1'b0;
        tick();
        start6 = 1'b0;
        din6 = 4'h0; din_valid6 = 1'b1; din_last6 = 1'b1; crc_rx6 = 6'h34;
        tick();
        din_valid6 = 1'b0; din_last6 = 1'b0;
        @(negedge clk);
        chk("crc6_valid", int'(crc_valid6), 1);
        chk("crc6_out", int'(crc_out6), 6'h34);
        chk("crc6_ok", int'(crc_ok6), 1);
        tick();
        @(negedge clk);
        chk("crc6_valid_pulse", int'(crc_valid6), 0);
        tick();

        // randomized messages
        for (int t = 0; t < 40; t++) begin
            m = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 6);
            mb.delete(); mg.delete();
            for (int i = 0; i < n; i++) begin
                mb.push_back(4'($urandom_range(0, 15)));
                mg.push_back($urandom_range(0, 2));
            end
            ec = 4'(model_crc(4, 13, 5, int'(m), mb));
            rx = ($urandom_range(0, 1) != 0) ? ec : 4'($urandom_range(0, 15));
            send_msg(m, rx, ec);
        end

        // abort: start collides with a last beat; the beat must be dropped
        do_start(1'b0);
        beat(4'h7, 1'b0, 4'h0);
        start = 1'b1; mode = 1'b0;
        din = 4'h9; din_valid = 1'b1; din_last = 1'b1;
        tick();
        start = 1'b0; din_valid = 1'b0; din_last = 1'b0;
        gap(3);
        beat(4'h0, 1'b1, 4'h3);
        begin
            exp_t e;
            e.due = acc_cyc + 1; e.crc = 4'h3; e.ok = 1'b1;
            expq.push_back(e);
        end
        repeat (4) tick();

        // reset mid-message: no crc_valid, outputs back to reset values
        do_start(1'b1);
        beat(4'h9, 1'b0, 4'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_crc_out", int'(crc_out), 4'h5);
        chk("midrst_crc_ok", int'(crc_ok), 0);
        chk("midrst_din_ready", int'(din_ready), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (4) tick();

        chk("exp_queue_drained", expq.size(), 0);
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
